pulse_period_monitor: RTL

- Receiver-side checker for single-cycle strobe trains produced by the team's clock-divider FSMs, e.g. a divide-by-3 "q" output.
- Measures the spacing between strobes, locks when the spacing matches the expected divide ratio for a run of periods, and flags errors once locked.
- Sits next to a divider in self-test and bring-up logic, on the same clock domain.

---
 rtl/pulse_period_monitor.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pulse_period_monitor.sv
// Strobe period monitor: measures spacing between single-cycle pulses, locks on DIV, flags errors.
// Optional PULSE_PERIOD_MINMAX_EN adds running period_min/period_max outputs.
module pulse_period_monitor #(
  parameter int unsigned DIV      = 3,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
`ifdef PULSE_PERIOD_MINMAX_EN
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max,
`endif
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {StIdle, StAcq, StLock} state_e;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] DivVal  = CNT_W'(DIV);
  localparam logic [3:0]       LockVal = 4'(LOCK_CNT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       match_q, match_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             meas, timeout;

  // cnt == 0 means no earlier pulse, so a pulse from IDLE never yields a measurement.
  assign meas    = pulse_in && (cnt_q != '0);
  assign timeout = !pulse_in && (cnt_q == CntMax);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    match_d     = match_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
      match_d = '0;
    end else begin
      if (pulse_in)              cnt_d = CNT_W'(1);
      else if (timeout)          cnt_d = '0;
      else if (cnt_q != '0)      cnt_d = cnt_q + CNT_W'(1);
      if (meas) begin
        period_d = cnt_q;
        valid_d  = 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (pulse_in) begin
            state_d = StAcq;
            match_d = '0;
          end
        end
        StAcq: begin
          if (meas) begin
            if (cnt_q == DivVal) begin
              if (match_q + 4'd1 == LockVal) begin
                state_d = StLock;
                match_d = '0;
              end else begin
                match_d = match_q + 4'd1;
              end
            end else begin
              match_d = '0;
            end
          end else if (timeout) begin
            state_d = StIdle;
          end
        end
        StLock: begin
          if (meas && (cnt_q != DivVal)) begin
            err_d   = 1'b1;
            state_d = StAcq;
            match_d = '0;
          end else if (timeout) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    locked_d = (state_d == StLock);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      match_q     <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign err          = err_q;
  assign err_count    = err_count_q;

`ifdef PULSE_PERIOD_MINMAX_EN
  logic [CNT_W-1:0] min_q, max_q;

  // Tracks every measurement; only reset clears the extremes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_q <= '1;
      max_q <= '0;
    end else if (valid_d) begin
      if (period_d < min_q) min_q <= period_d;
      if (period_d > max_q) max_q <= period_d;
    end
  end

  assign period_min = min_q;
  assign period_max = max_q;
`endif

endmodule
